// File: rtl/seq_mul.sv
// Signed 16x16 radix-2 Booth sequential multiplier with valid/ready on both sides.
// Optional build macro: SEQ_MUL_ZERO_BYPASS_EN (zero operand skips straight to DONE).
module seq_mul (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] q_i,
    input  logic [15:0] m_i,
    input  logic        src_valid_i,
    output logic        src_ready_o,
    output logic        dest_valid_o,
    input  logic        dest_ready_i,
    output logic [31:0] p_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q;
    logic [16:0] a_q;
    logic [16:0] m_q;
    logic [15:0] q_q;
    logic        qm1_q;
    logic [4:0]  cnt_q;
    logic [31:0] p_q;

    logic [16:0] sum;
    logic [16:0] a_d;
    logic [15:0] q_d;
    logic        qm1_d;

    // One Booth step: conditional add/subtract, then arithmetic shift of {A, Q, q[-1]}.
    always_comb begin
        sum = a_q;
        case ({q_q[0], qm1_q})
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q - m_q;
            default: sum = a_q;
        endcase
        a_d   = {sum[16], sum[16:1]};
        q_d   = {sum[0], q_q[15:1]};
        qm1_d = q_q[0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (src_valid_i) begin
                        m_q   <= {m_i[15], m_i};
                        q_q   <= q_i;
                        a_q   <= '0;
                        qm1_q <= 1'b0;
                        cnt_q <= 5'd16;
`ifdef SEQ_MUL_ZERO_BYPASS_EN
                        if (q_i == 16'd0 || m_i == 16'd0) begin
                            p_q     <= '0;
                            state_q <= StDone;
                        end else begin
                            state_q <= StBusy;
                        end
`else
                        state_q <= StBusy;
`endif
                    end
                end
                StBusy: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    qm1_q <= qm1_d;
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        p_q     <= {a_d[15:0], q_d};
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (dest_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign src_ready_o  = (state_q == StIdle);
    assign dest_valid_o = (state_q == StDone);
    assign p_o          = p_q;

endmodule

// File: tb/tb_seq_mul.sv
// Directed and random self-checking bench for seq_mul; inputs driven and outputs
// sampled on the falling clock edge.
module tb_seq_mul;

    logic        clk;
    logic        rst_ni;
    logic [15:0] q;
    logic [15:0] m;
    logic        src_valid;
    logic        src_ready;
    logic        dest_valid;
    logic        dest_ready;
    logic [31:0] p;

    int n_checks = 0;
    int n_pass   = 0;

    seq_mul u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .q_i         (q),
        .m_i         (m),
        .src_valid_i (src_valid),
        .src_ready_o (src_ready),
        .dest_valid_o(dest_valid),
        .dest_ready_i(dest_ready),
        .p_o         (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b);
`ifdef SEQ_MUL_ZERO_BYPASS_EN
        return (a == 16'd0 || b == 16'd0) ? 0 : 16;
`else
        return 16;
`endif
    endfunction

    // Called at a falling edge with src_ready high; returns at the falling edge after
    // the output handshake, so consecutive calls give back-to-back transactions.
    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input bit full);
        int lat;
        q          = a;
        m          = b;
        src_valid  = 1'b1;
        dest_ready = 1'b1;
        @(negedge clk);
        src_valid = 1'b0;
        q         = 16'($urandom);
        m         = 16'($urandom);
        lat       = 0;
        while (!dest_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (full) check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat(a, b)));
        check_eq({tag, "_p"}, p, exp);
        @(negedge clk);
        if (full) begin
            check_eq({tag, "_src_ready"}, {31'b0, src_ready}, 32'd1);
            check_eq({tag, "_dest_valid"}, {31'b0, dest_valid}, 32'd0);
        end
    endtask

    initial begin
        int lat;
        logic [15:0] ra;
        logic [15:0] rb;
        int sa;
        int sb;

        rst_ni     = 1'b0;
        q          = '0;
        m          = '0;
        src_valid  = 1'b0;
        dest_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_src_ready", {31'b0, src_ready}, 32'd1);
        check_eq("rst_dest_valid", {31'b0, dest_valid}, 32'd0);
        check_eq("rst_p", p, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk);

        run("1x3", 16'd1, 16'd3, 32'd3, 1'b1);
        run("m1x7", 16'hFFFF, 16'd7, 32'hFFFF_FFF9, 1'b1);
        run("m2x8", 16'hFFFE, 16'd8, 32'hFFFF_FFF0, 1'b1);
        run("0x20", 16'd0, 16'd20, 32'd0, 1'b1);

        // Hold in DONE with dest_ready low while src_valid pulses with junk operands.
        q          = 16'hFFD3;  // -45
        m          = 16'hFF9C;  // -100
        src_valid  = 1'b1;
        dest_ready = 1'b0;
        @(negedge clk);
        lat = 0;
        while (!dest_valid && lat < 40) begin
            src_valid = lat[0];
            q         = 16'($urandom);
            m         = 16'($urandom);
            @(negedge clk);
            lat++;
            if (lat == 5) check_eq("hold_busy_src_ready", {31'b0, src_ready}, 32'd0);
        end
        check_eq("hold_lat", 32'(lat), 32'd16);
        for (int i = 0; i < 4; i++) begin
            src_valid = i[0];
            @(negedge clk);
            check_eq("hold_p", p, 32'd4500);
            check_eq("hold_dest_valid", {31'b0, dest_valid}, 32'd1);
        end
        check_eq("hold_src_ready", {31'b0, src_ready}, 32'd0);
        src_valid  = 1'b0;
        dest_ready = 1'b1;
        @(negedge clk);
        check_eq("hold_release_src_ready", {31'b0, src_ready}, 32'd1);
        check_eq("hold_p_after", p, 32'd4500);

        run("m56x29193", 16'hFFC8, 16'd29193, 32'hFFE7_0E08, 1'b1);
        run("min_x_min", 16'h8000, 16'h8000, 32'h4000_0000, 1'b1);
        run("min_x_max", 16'h8000, 16'h7FFF, 32'hC000_8000, 1'b1);

        // Reset mid-BUSY aborts the transaction.
        q         = 16'd100;
        m         = 16'd100;
        src_valid = 1'b1;
        @(negedge clk);
        src_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst_ni = 1'b0;
        #1;
        check_eq("midrst_src_ready", {31'b0, src_ready}, 32'd1);
        check_eq("midrst_dest_valid", {31'b0, dest_valid}, 32'd0);
        check_eq("midrst_p", p, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        run("2x7", 16'd2, 16'd7, 32'd14, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            sa = int'($signed(ra));
            sb = int'($signed(rb));
            run("rand", ra, rb, 32'(sa * sb), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_mul.md
# seq_mul

Signed 16×16 sequential multiplier with valid/ready handshakes on both input and output. It accepts one operand pair, computes the exact 32-bit two's-complement product over 16 clock cycles using radix-2 Booth recoding, and holds the result until the downstream consumer accepts it. It is a single-transaction, non-pipelined arithmetic leaf placed between a producer and a consumer stage.

## Interface
- No parameters; widths are fixed at 16-bit operands and a 32-bit product.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- q  input  16  signed multiplier; sampled on the accepting edge.
- m  input  16  signed multiplicand; sampled on the accepting edge.
- src_valid  input  1  producer asserts that q/m are valid.
- src_ready  output  1  block is idle and able to accept an operand pair.
- dest_valid  output  1  p holds a completed product.
- dest_ready  input  1  consumer is able to take p.
- p  output  32  signed product q×m, registered.

## Operation
- States:
  - IDLE: src_ready=1, dest_valid=0.
  - BUSY: src_ready=0, dest_valid=0.
  - DONE: src_ready=0, dest_valid=1.
- Input accept: a rising edge with src_ready && src_valid latches q and m, clears the 17-bit accumulator and the Booth bit q[-1], loads the step count 16, and moves IDLE→BUSY.
- BUSY step, one per cycle, on the pair {Q[0], q[-1]}:
  - 01: A += M.
  - 10: A −= M.
  - 00 or 11: no add.
  - Then arithmetic-shift {A, Q, q[-1]} right by one.
- Width rule: M is sign-extended to 17 bits, so every operand pair is exact, including −32768×−32768 = 0x4000_0000.
- After the 16th step, p is loaded with {A[15:0], Q} and the state moves BUSY→DONE.
- DONE→IDLE on an edge where dest_ready=1. p keeps its value after the handshake and until the next result is loaded.
- src_valid is ignored in BUSY and in DONE. The latched operands are not affected by changes on q/m after acceptance.
- Only one transaction is in flight at a time. There is no input buffering.

## Timing
- Reset (rst=0, asynchronous): state goes to IDLE; src_ready=1, dest_valid=0, p=0, and internal registers are cleared. Asserting reset mid-operation aborts the transaction and discards the result.
- src_ready and dest_valid are decoded directly from the state register, with no combinational path from any input.
- Latency: acceptance at edge T0; dest_valid rises after edge T16 with p already valid and stable. p must not change while dest_valid=1.
- If dest_ready is already high when dest_valid rises, the handshake completes at the next edge (T17) and src_ready returns at T17. The earliest next acceptance is at edge T18, giving a throughput of one product per 18 cycles.
- If dest_ready=0, the block stays in DONE indefinitely with p held.

## Configuration
- SEQ_MUL_ZERO_BYPASS_EN:
  - Defined: if the latched q or m is zero, the block goes IDLE→DONE on the accepting edge with p=0, so dest_valid is asserted after T0 (1-cycle latency).
  - Undefined: every operand pair takes the full 16-cycle BUSY path.
  - All other behaviour is identical in both builds.

## Test plan
- Reset, then q=1, m=3 with dest_ready=1 → p=3 at dest_valid, asserted 16 cycles after acceptance (1 cycle with SEQ_MUL_ZERO_BYPASS_EN irrelevant here); src_ready back at T17.
- q=0xFFFF(−1), m=7 → p=0xFFFF_FFF9; q=0xFFFE(−2), m=8 → p=0xFFFF_FFF0; q=0, m=20 → p=0 (1-cycle latency with bypass enabled).
- q=−45, m=−100, then dest_ready=0 while src_valid pulses with other operands during BUSY and DONE → pulses are ignored; p=4500 held stable until dest_ready=1.
- q=−56, m=29193 → p=−1634808; q=−32768, m=−32768 → p=0x4000_0000; q=−32768, m=32767 → p=0xC000_8000.
- Assert rst mid-BUSY → src_ready=1, dest_valid=0, p=0 immediately; the next transaction (2×7) yields p=14.
- 1000 random signed pairs with back-to-back handshakes → every p equals the sign-extended q×m.
